ibex_neur_issue: RTL
====================

// Module: ibex_neur_issue
// PURPOSE
//  Issue stage for custom neural instructions, sitting between the ID decoder and ibex_ex_block.
//  - Holds the neuron configuration registers: mode, out_options, position.
//  - Sequences MAC, BIAS and GETRES ops onto the EX strobes neur_valid_in/neur_bias_in/get_res.
//  - Enforces the level handshake against ex_valid, returns GETRES results to writeback,
//    and guards against a hung neural unit with a timeout.
// PARAMETERS
//  TimeoutCycles  64  cycles a strobe may stay high without ex_valid_i before abort (>=2)
//  MacCntW        16  width of saturating issued-MAC counter
// PORTS
//  clk_i               in   1   clock
//  rst_ni              in   1   asynchronous active-low reset
//  req_valid_i         in   1   decoder presents a neural op
//  req_ready_o         out  1   op accepted this cycle when valid&ready
//  req_op_i            in   3   0 CFG_MODE, 1 CFG_POS, 2 MAC, 3 BIAS, 4 GETRES, 5-7 illegal
//  req_rs1_i           in   32  operand A (mode / position / weights)
//  req_rs2_i           in   32  operand B (out_options / input value)
//  req_rd_i            in   5   destination register (GETRES only)
//  flush_i             in   1   pipeline flush, aborts the in-flight op
//  neur_valid_in_o     out  1   MAC strobe to EX
//  neur_bias_in_o      out  1   BIAS strobe to EX
//  get_res_o           out  1   GETRES strobe to EX
//  neur_mode_o         out  32  configured mode
//  neur_out_options_o  out  32  configured output options
//  neur_position_o     out  32  configured position
//  weights_o           out  32  latched rs1 of the in-flight op
//  input_val_o         out  32  latched rs2 of the in-flight op
//  ex_valid_i          in   1   EX completion, meaningful only while a strobe is high
//  ex_result_i         in   32  EX result
//  wb_valid_o          out  1   one-cycle writeback pulse
//  wb_rd_o             out  5   writeback register address
//  wb_wdata_o          out  32  writeback data
//  busy_o              out  1   FSM not IDLE
//  err_o               out  1   one-cycle pulse on illegal op or timeout
//  mac_cnt_o           out  MacCntW  saturating count of completed MACs
// BEHAVIOUR
//  - Reset: all outputs and registers 0, FSM in IDLE.
//  - FSM states: IDLE, ISSUE, WB. req_ready_o = (state==IDLE).
//  - IDLE, accept of CFG_MODE: mode<=rs1, out_options<=rs2 at the next edge. No strobe; stay IDLE.
//  - IDLE, accept of CFG_POS: position<=rs1. Stay IDLE.
//  - IDLE, accept of illegal op (5-7): err_o pulses the next cycle. Op is consumed; stay IDLE.
//  - IDLE, accept of MAC/BIAS/GETRES: latch rs1->weights_o, rs2->input_val_o, op and rd;
//    go to ISSUE and clear the timer.
//  - ISSUE:
//    - Exactly one strobe matching the op is high, from the cycle after accept until the cycle
//      ex_valid_i is seen (inclusive). weights/input are stable throughout.
//    - ex_valid_i=1 with a MAC: mac_cnt_o++ (saturates at all-ones); go to IDLE.
//    - ex_valid_i=1 with a BIAS: go to IDLE.
//    - ex_valid_i=1 with a GETRES: capture ex_result_i and rd; go to WB.
//    - ex_valid_i=0: timer++. When timer reaches TimeoutCycles-1 with no ex_valid_i:
//      strobe drops, err_o pulses, go to IDLE, no writeback.
//  - WB: wb_valid_o=1 for exactly one cycle with the captured data; then IDLE.
//    A GETRES result is visible 2 cycles after ex_valid_i.
//  - Strobes are registered outputs, never combinational from req_*; at most one high at a time.
//  - flush_i: in ISSUE or WB, the next state is IDLE.
//    - Strobe and wb_valid_o are low the next cycle; no counter update, no err.
//    - Configuration registers are preserved.
//    - flush_i together with ex_valid_i: flush wins.
//    - In IDLE, flush_i blocks acceptance that cycle (req_ready_o=0).
//  - Config writes never happen outside IDLE, so mode/options/position are constant while a
//    strobe is high.
//  - Asynchronous reset mid-operation: everything returns to reset values immediately,
//    including strobes.
// STRUCTURE
//  - Shared package ibex_neur_pkg:
//    - typedef neur_op_e (3-bit op encodings above);
//    - typedef neur_issue_state_e {IDLE, ISSUE, WB};
//    - constants NEUR_OP_ILLEGAL_MIN=5.
//  - One natural sub-module: ibex_neur_timeout, a loadable counter with clear, enable and
//    expire outputs, parameterised by TimeoutCycles.
//  - Everything else is flat in ibex_neur_issue.
// TESTING
//  - CFG_MODE rs1=32'h2, rs2=32'h5; then CFG_POS rs1=32'h3:
//    - mode=2, options=5, position=3 one cycle after each accept;
//    - no strobe; busy_o stays 0.
//  - MAC rs1=32'h01020304, rs2=32'h05060708, EX returns ex_valid_i 3 cycles after strobe rise:
//    - neur_valid_in_o high for 3 cycles with operands stable;
//    - mac_cnt_o=1; req_ready_o returns 1 the cycle after ex_valid_i.
//  - GETRES rd=5'd10, ex_result_i=32'hDEAD_BEEF with ex_valid_i:
//    - wb_valid_o pulses once with wb_rd_o=10, wb_wdata_o=32'hDEADBEEF, 2 cycles after ex_valid_i.
//  - MAC with ex_valid_i held 0:
//    - strobe drops after TimeoutCycles=64 cycles; err_o pulses once;
//    - mac_cnt_o unchanged; FSM returns to IDLE.
//  - flush_i asserted in the same cycle as ex_valid_i during GETRES:
//    - no wb_valid_o; strobe low the next cycle; config registers intact.
//  - Illegal op 3'd6 -> err_o pulses once, no strobe.
//  - 65536+ completed MACs -> mac_cnt_o saturates at 16'hFFFF.
//  - rst_ni pulsed low mid-ISSUE -> all strobes and outputs 0 immediately.

Source files
------------

// File: rtl/ibex_neur_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ibex_neur_pkg
// Description : Shared types and constants for the neural-op issue stage.
// Revision    : 1.0 - initial release
// ============================================================================
package ibex_neur_pkg;

    // Decoder op encodings; values from NEUR_OP_ILLEGAL_MIN upward are illegal.
    typedef enum logic [2:0] {
        NEUR_OP_CFG_MODE = 3'd0,
        NEUR_OP_CFG_POS  = 3'd1,
        NEUR_OP_MAC      = 3'd2,
        NEUR_OP_BIAS     = 3'd3,
        NEUR_OP_GETRES   = 3'd4
    } neur_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WB    = 2'd2
    } neur_issue_state_e;

    localparam logic [2:0] NEUR_OP_ILLEGAL_MIN = 3'd5;

    // Ops that drive an EX strobe and occupy the issue FSM.
    function automatic logic neur_op_is_issue(input logic [2:0] op);
        return (op == NEUR_OP_MAC) || (op == NEUR_OP_BIAS) || (op == NEUR_OP_GETRES);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ibex_neur_timeout.sv
`default_nettype none
// ============================================================================
// Module      : ibex_neur_timeout
// Description : Cycle counter that flags when an EX strobe has waited too long.
//               Clear loads zero; counting stops at the terminal value.
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_neur_timeout #(
    parameter int unsigned TimeoutCycles = 64
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CNT_W = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(TimeoutCycles - 1);

    logic [CNT_W-1:0] cnt_q;

    assign expire_o = (cnt_q == LAST_VAL);

    // Count waiting cycles; clear has priority and the count holds once expired.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (en_i && !expire_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ibex_neur_issue.sv
`default_nettype none
// ============================================================================
// Module      : ibex_neur_issue
// Description : Issue stage for custom neural ops. Holds neuron configuration,
//               drives MAC/BIAS/GETRES strobes into EX with a level handshake,
//               returns GETRES results to writeback and aborts on timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_neur_issue
    import ibex_neur_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 64,
    parameter int unsigned MacCntW       = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [2:0]         req_op_i,
    input  logic [31:0]        req_rs1_i,
    input  logic [31:0]        req_rs2_i,
    input  logic [4:0]         req_rd_i,
    input  logic               flush_i,
    output logic               neur_valid_in_o,
    output logic               neur_bias_in_o,
    output logic               get_res_o,
    output logic [31:0]        neur_mode_o,
    output logic [31:0]        neur_out_options_o,
    output logic [31:0]        neur_position_o,
    output logic [31:0]        weights_o,
    output logic [31:0]        input_val_o,
    input  logic               ex_valid_i,
    input  logic [31:0]        ex_result_i,
    output logic               wb_valid_o,
    output logic [4:0]         wb_rd_o,
    output logic [31:0]        wb_wdata_o,
    output logic               busy_o,
    output logic               err_o,
    output logic [MacCntW-1:0] mac_cnt_o
);

    neur_issue_state_e state_q, state_d;
    neur_op_e          op_q;
    logic [4:0]        rd_q;
    logic [31:0]       weights_q, input_q;
    logic [31:0]       mode_q, options_q, position_q;
    logic [4:0]        wb_rd_q;
    logic [31:0]       wb_wdata_q;
    logic              wb_valid_q, wb_valid_d;
    logic              err_q, err_d;
    logic [MacCntW-1:0] mac_cnt_q;

    logic w_accept;
    logic w_issue_load;
    logic w_wb_capture;
    logic w_mac_inc;
    logic w_timer_clear;
    logic w_timer_en;
    logic w_timer_expire;

    assign req_ready_o = (state_q == IDLE) && !flush_i;
    assign w_accept    = req_valid_i && req_ready_o;

    // Strobes decode registered state only, so they never follow req_* combinationally.
    assign neur_valid_in_o = (state_q == ISSUE) && (op_q == NEUR_OP_MAC);
    assign neur_bias_in_o  = (state_q == ISSUE) && (op_q == NEUR_OP_BIAS);
    assign get_res_o       = (state_q == ISSUE) && (op_q == NEUR_OP_GETRES);

    assign busy_o             = (state_q != IDLE);
    assign weights_o          = weights_q;
    assign input_val_o        = input_q;
    assign neur_mode_o        = mode_q;
    assign neur_out_options_o = options_q;
    assign neur_position_o    = position_q;
    assign wb_valid_o         = wb_valid_q;
    assign wb_rd_o            = wb_rd_q;
    assign wb_wdata_o         = wb_wdata_q;
    assign err_o              = err_q;
    assign mac_cnt_o          = mac_cnt_q;

    ibex_neur_timeout #(
        .TimeoutCycles (TimeoutCycles)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (w_timer_clear),
        .en_i     (w_timer_en),
        .expire_o (w_timer_expire)
    );

    // Next-state and control decode; flush beats completion and timeout.
    always_comb begin
        state_d       = state_q;
        w_issue_load  = 1'b0;
        w_wb_capture  = 1'b0;
        w_mac_inc     = 1'b0;
        w_timer_clear = 1'b0;
        w_timer_en    = 1'b0;
        err_d         = 1'b0;
        wb_valid_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    if (req_op_i >= NEUR_OP_ILLEGAL_MIN) begin
                        err_d = 1'b1;
                    end else if (neur_op_is_issue(req_op_i)) begin
                        w_issue_load  = 1'b1;
                        w_timer_clear = 1'b1;
                        state_d       = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (ex_valid_i) begin
                    case (op_q)
                        NEUR_OP_MAC: begin
                            w_mac_inc = 1'b1;
                            state_d   = IDLE;
                        end
                        NEUR_OP_GETRES: begin
                            w_wb_capture = 1'b1;
                            state_d      = WB;
                        end
                        default: state_d = IDLE;
                    endcase
                end else if (w_timer_expire) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    w_timer_en = 1'b1;
                end
            end
            WB: begin
                wb_valid_d = !flush_i;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, single-cycle pulses and the saturating MAC counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            wb_valid_q <= 1'b0;
            err_q      <= 1'b0;
            mac_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            wb_valid_q <= wb_valid_d;
            err_q      <= err_d;
            if (w_mac_inc && (mac_cnt_q != {MacCntW{1'b1}})) begin
                mac_cnt_q <= mac_cnt_q + 1'b1;
            end
        end
    end

    // Operand latch for the in-flight op, plus writeback capture.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q       <= NEUR_OP_CFG_MODE;
            rd_q       <= '0;
            weights_q  <= '0;
            input_q    <= '0;
            wb_rd_q    <= '0;
            wb_wdata_q <= '0;
        end else begin
            if (w_issue_load) begin
                op_q      <= neur_op_e'(req_op_i);
                rd_q      <= req_rd_i;
                weights_q <= req_rs1_i;
                input_q   <= req_rs2_i;
            end
            if (w_wb_capture) begin
                wb_rd_q    <= rd_q;
                wb_wdata_q <= ex_result_i;
            end
        end
    end

    // Configuration registers; written only on an IDLE accept.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q     <= '0;
            options_q  <= '0;
            position_q <= '0;
        end else if (w_accept) begin
            if (req_op_i == NEUR_OP_CFG_MODE) begin
                mode_q    <= req_rs1_i;
                options_q <= req_rs2_i;
            end else if (req_op_i == NEUR_OP_CFG_POS) begin
                position_q <= req_rs1_i;
            end
        end
    end

endmodule
`default_nettype wire
